// File: rtl/cache_line_fetcher.sv
// Miss-fill engine: turns one line tag into one AXI4 INCR read burst and streams
// the returned beats through a 2-entry buffer with per-beat error and last flags.
module cache_line_fetcher #(
  parameter int                    TAGS_WIDTH     = 48,
  parameter int                    CACHE_SIZE     = 512,
  parameter int                    DATA_PORT_SIZE = 512,
  parameter int                    ADDR_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_tvalid,
  output logic                      req_tready,
  input  logic [TAGS_WIDTH-1:0]     req_tdata,
  output logic                      resp_tvalid,
  input  logic                      resp_tready,
  output logic [DATA_PORT_SIZE-1:0] resp_tdata,
  output logic                      resp_tlast,
  output logic                      resp_terr,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_PORT_SIZE-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      busy,
  output logic [15:0]               err_count
);
  localparam int         NBEATS     = CACHE_SIZE / DATA_PORT_SIZE;
  localparam int         LINE_SHIFT = $clog2(CACHE_SIZE / 8);
  localparam int         BEAT_LOG   = $clog2(DATA_PORT_SIZE / 8);
  localparam logic [7:0] LAST_BEAT  = 8'(NBEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef struct packed {
    logic [DATA_PORT_SIZE-1:0] data;
    logic                      err;
    logic                      last;
  } beat_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  beat_t [1:0]             buf_q, buf_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [15:0]             err_count_q, err_count_d;
  logic                    live_q, live_d;

  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    push, pop, beat_last;
  logic [1:0]              ev;
  logic [16:0]             err_sum;

  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = 3'(BEAT_LOG);
  assign m_axi_arburst = 2'b01;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = (state_q == S_ADDR);
  assign m_axi_rready  = (state_q == S_DATA) && (cnt_q != 2'd2);
  // live_q keeps req_tready low while reset is held, since IDLE+empty is the reset state
  assign req_tready    = live_q && (state_q == S_IDLE) && (cnt_q == 2'd0);
  assign resp_tvalid   = (cnt_q != 2'd0);
  assign resp_tdata    = buf_q[rd_ptr_q].data;
  assign resp_terr     = buf_q[rd_ptr_q].err;
  assign resp_tlast    = buf_q[rd_ptr_q].last;
  assign busy          = (state_q != S_IDLE) || (cnt_q != 2'd0);
  assign err_count     = err_count_q;

  assign req_addr  = BASE_ADDR + (ADDR_WIDTH'(req_tdata) << LINE_SHIFT);
  assign push      = m_axi_rvalid && m_axi_rready;
  assign pop       = resp_tvalid && resp_tready;
  assign beat_last = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    beat_cnt_d  = beat_cnt_q;
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    live_d      = 1'b1;
    ev          = 2'd0;
    err_sum     = 17'd0;

    unique case (state_q)
      S_IDLE: if (req_tvalid && req_tready) begin
        araddr_d = req_addr;
        state_d  = S_ADDR;
      end
      S_ADDR: if (m_axi_arready) begin
        beat_cnt_d = 8'd0;
        state_d    = S_DATA;
      end
      S_DATA: if (push) begin
        beat_cnt_d = beat_cnt_q + 8'd1;
        if (beat_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // tlast comes from the beat counter; rlast only feeds the error counter
    if (push) begin
      buf_d[wr_ptr_q] = '{data: m_axi_rdata, err: (m_axi_rresp != 2'b00), last: beat_last};
      wr_ptr_d = ~wr_ptr_q;
      ev       = 2'(m_axi_rresp != 2'b00) + 2'(m_axi_rlast != beat_last);
      err_sum  = {1'b0, err_count_q} + 17'(ev);
      err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      araddr_q    <= '0;
      beat_cnt_q  <= 8'd0;
      buf_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      err_count_q <= 16'd0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      beat_cnt_q  <= beat_cnt_d;
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      live_q      <= live_d;
    end
  end
endmodule

// File: tb/tb_cache_line_fetcher.sv
// Directed bench: a 4-beat fetcher (2048/512, 48-bit address) driven from a vector
// table plus corner sequences, and a 1-beat fetcher for the latency case.
module tb_cache_line_fetcher;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-beat instance
  logic         req_tvalid, req_tready, resp_tvalid, resp_tready, resp_tlast, resp_terr;
  logic [47:0]  req_tdata, m_axi_araddr;
  logic [511:0] resp_tdata, m_axi_rdata;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst, m_axi_rresp;
  logic         m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready, busy;
  logic [15:0]  err_count;

  cache_line_fetcher #(.TAGS_WIDTH(48), .CACHE_SIZE(2048), .DATA_PORT_SIZE(512),
                       .ADDR_WIDTH(48), .BASE_ADDR(48'h1000)) u_dut (
    .clk(clk), .rst(rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
    .resp_tlast(resp_tlast), .resp_terr(resp_terr),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .err_count(err_count));

  // 1-beat instance
  logic         n1_req_tvalid, n1_req_tready, n1_resp_tvalid, n1_resp_tready, n1_resp_tlast, n1_resp_terr;
  logic [47:0]  n1_req_tdata;
  logic [63:0]  n1_araddr;
  logic [511:0] n1_resp_tdata, n1_rdata;
  logic [7:0]   n1_arlen;
  logic [2:0]   n1_arsize;
  logic [1:0]   n1_arburst, n1_rresp;
  logic         n1_arvalid, n1_arready, n1_rlast, n1_rvalid, n1_rready, n1_busy;
  logic [15:0]  n1_err_count;

  cache_line_fetcher #(.TAGS_WIDTH(48), .CACHE_SIZE(512), .DATA_PORT_SIZE(512),
                       .ADDR_WIDTH(64), .BASE_ADDR(64'h1000)) u_n1 (
    .clk(clk), .rst(rst),
    .req_tvalid(n1_req_tvalid), .req_tready(n1_req_tready), .req_tdata(n1_req_tdata),
    .resp_tvalid(n1_resp_tvalid), .resp_tready(n1_resp_tready), .resp_tdata(n1_resp_tdata),
    .resp_tlast(n1_resp_tlast), .resp_terr(n1_resp_terr),
    .m_axi_araddr(n1_araddr), .m_axi_arlen(n1_arlen), .m_axi_arsize(n1_arsize),
    .m_axi_arburst(n1_arburst), .m_axi_arvalid(n1_arvalid), .m_axi_arready(n1_arready),
    .m_axi_rdata(n1_rdata), .m_axi_rresp(n1_rresp), .m_axi_rlast(n1_rlast),
    .m_axi_rvalid(n1_rvalid), .m_axi_rready(n1_rready),
    .busy(n1_busy), .err_count(n1_err_count));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [511:0] dpat(input logic [47:0] a, input int b);
    return {448'h0, 8'hD0, a, b[7:0]};
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Slave models run on the falling edge; handshakes are judged from values held
  // there, which are the values present at the following rising edge.
  logic [3:0]   err_mask, rlast_mask;
  int           ar_wait, r_acc, stab_err;
  logic         sl_active, ar_hs_q, r_hs_q, ar_hold, rsp_hold;
  int           sl_beat;
  logic [47:0]  sl_addr, ar_addr_q, ar_seen_addr, ar_hold_addr;
  logic [511:0] hold_data;
  logic [513:0] mon_q[$];

  always @(negedge clk) begin
    if (rst) begin
      sl_active = 1'b0; sl_beat = 0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    end else begin
      if (ar_hs_q) begin sl_active = 1'b1; sl_beat = 0; sl_addr = ar_addr_q; ar_seen_addr = ar_addr_q; end
      if (r_hs_q) begin sl_beat++; r_acc++; if (sl_beat == 4) sl_active = 1'b0; end
      if (m_axi_arvalid && ar_wait > 0) ar_wait--;
      m_axi_arready = m_axi_arvalid && (ar_wait == 0) && !sl_active;
      m_axi_rvalid  = sl_active;
      m_axi_rdata   = (sl_beat < 4) ? dpat(sl_addr, sl_beat) : '0;
      m_axi_rresp   = (sl_beat < 4 && err_mask[sl_beat[1:0]]) ? 2'b10 : 2'b00;
      m_axi_rlast   = (sl_beat < 4) && rlast_mask[sl_beat[1:0]];
      if (ar_hold && (!m_axi_arvalid || m_axi_araddr != ar_hold_addr)) stab_err++;
      if (rsp_hold && (!resp_tvalid || resp_tdata != hold_data)) stab_err++;
      if (resp_tvalid && resp_tready) mon_q.push_back({resp_tlast, resp_terr, resp_tdata});
    end
    ar_hs_q      = !rst && m_axi_arvalid && m_axi_arready;
    ar_addr_q    = m_axi_araddr;
    ar_hold      = !rst && m_axi_arvalid && !m_axi_arready;
    ar_hold_addr = m_axi_araddr;
    r_hs_q       = !rst && m_axi_rvalid && m_axi_rready;
    rsp_hold     = !rst && resp_tvalid && !resp_tready;
    hold_data    = resp_tdata;
  end

  logic        n1_active, n1_ar_hs_q, n1_r_hs_q;
  logic [63:0] n1_sl_addr;
  always @(negedge clk) begin
    if (rst) begin
      n1_active = 1'b0; n1_arready = 1'b0; n1_rvalid = 1'b0;
      n1_rdata = '0; n1_rresp = 2'b00; n1_rlast = 1'b0;
    end else begin
      if (n1_ar_hs_q) begin n1_active = 1'b1; n1_sl_addr = n1_araddr; end
      if (n1_r_hs_q) n1_active = 1'b0;
      n1_arready = !n1_active;
      n1_rvalid  = n1_active;
      n1_rdata   = dpat(n1_sl_addr[47:0], 0);
      n1_rresp   = 2'b00;
      n1_rlast   = 1'b1;
    end
    n1_ar_hs_q = !rst && n1_arvalid && n1_arready;
    n1_r_hs_q  = !rst && n1_rvalid && n1_rready;
  end

  task automatic do_req(input logic [47:0] tag);
    int c = 0;
    while (!req_tready && c < 50) begin step; c++; end
    check("req_tready_wait", 1'(c < 50), 1'b1);
    req_tvalid = 1'b1; req_tdata = tag;
    step;
    req_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int nbeats);
    int c = 0;
    while ((mon_q.size() < nbeats || busy) && c < 200) begin step; c++; end
    check("fill_timeout", 1'(c < 200), 1'b1);
  endtask

  task automatic check_beats(input string nm, input logic [47:0] addr, input logic [3:0] emask);
    check({nm, "_nbeats"}, mon_q.size(), 4);
    for (int b = 0; b < 4; b++) begin
      if (b < mon_q.size()) begin
        check({nm, "_data"}, mon_q[b][511:0], dpat(addr, b));
        check({nm, "_tlast"}, mon_q[b][513], 1'(b == 3));
        check({nm, "_terr"}, mon_q[b][512], emask[b]);
      end
    end
  endtask

  typedef struct {
    logic [47:0] tag;
    logic [47:0] exp_addr;
    logic [3:0]  err_mask;
    logic [3:0]  rlast_mask;
    int          err_delta;
    int          ar_stall;
  } vec_t;
  vec_t vec[4];

  initial begin
    int exp_err = 0;
    int lat;
    int c;
    // err_delta: one per non-OKAY beat plus one per beat whose rlast disagrees with beat==3
    vec[0] = '{48'h1,            48'h1100,  4'b0000, 4'b1000, 0, 0};
    vec[1] = '{48'h10,           48'h2000,  4'b0010, 4'b1100, 2, 2};
    vec[2] = '{48'hFFFF_FFFF_FFFF, 48'h0F00, 4'b0000, 4'b1000, 0, 0};
    vec[3] = '{48'hABC,          48'hACC00, 4'b1001, 4'b0001, 4, 1};

    rst = 1'b1; req_tvalid = 1'b0; req_tdata = '0; resp_tready = 1'b1;
    n1_req_tvalid = 1'b0; n1_req_tdata = '0; n1_resp_tready = 1'b1;
    err_mask = 4'b0000; rlast_mask = 4'b1000; ar_wait = 0; r_acc = 0; stab_err = 0;
    repeat (3) step;

    check("rst_req_tready", req_tready, 0);
    check("rst_resp_tvalid", resp_tvalid, 0);
    check("rst_resp_tdata", resp_tdata, 0);
    check("rst_resp_flags", {resp_tlast, resp_terr}, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("arlen", m_axi_arlen, 3);
    check("arsize", m_axi_arsize, 6);
    check("arburst", m_axi_arburst, 1);

    rst = 1'b0;
    step;
    check("req_tready_after_rst", req_tready, 1);
    check("n1_req_tready_after_rst", n1_req_tready, 1);

    // Single-beat line: request handshake in cycle t, resp valid in cycle t+3
    n1_req_tvalid = 1'b1; n1_req_tdata = 48'h3;
    step;
    n1_req_tvalid = 1'b0;
    lat = 1;
    check("n1_arvalid", n1_arvalid, 1);
    check("n1_araddr", n1_araddr, 64'h10C0);
    check("n1_arlen", n1_arlen, 0);
    while (!n1_resp_tvalid && lat < 20) begin step; lat++; end
    check("n1_latency", lat, 3);
    check("n1_data", n1_resp_tdata, dpat(48'h10C0, 0));
    check("n1_tlast", n1_resp_tlast, 1);
    check("n1_terr", n1_resp_terr, 0);
    step;
    check("n1_err_count", n1_err_count, 0);

    for (int i = 0; i < 4; i++) begin
      err_mask = vec[i].err_mask; rlast_mask = vec[i].rlast_mask; ar_wait = vec[i].ar_stall;
      mon_q.delete();
      do_req(vec[i].tag);
      wait_done(4);
      exp_err += vec[i].err_delta;
      check($sformatf("v%0d_araddr", i), ar_seen_addr, vec[i].exp_addr);
      check_beats($sformatf("v%0d", i), vec[i].exp_addr, vec[i].err_mask);
      check($sformatf("v%0d_err_count", i), err_count, exp_err);
    end

    // Sink stalled: only two beats may enter the buffer
    err_mask = 4'b0000; rlast_mask = 4'b1000; resp_tready = 1'b0; r_acc = 0;
    mon_q.delete();
    do_req(48'h5);
    repeat (10) step;
    check("bp_beats_accepted", r_acc, 2);
    check("bp_rready_low", m_axi_rready, 0);
    check("bp_resp_tvalid", resp_tvalid, 1);
    check("bp_head", resp_tdata, dpat(48'h1500, 0));
    resp_tready = 1'b1;
    wait_done(4);
    check_beats("bp", 48'h1500, 4'b0000);
    check("bp_err_count", err_count, exp_err);

    // Reset with two beats buffered mid-fill
    err_mask = 4'b0001; resp_tready = 1'b0; r_acc = 0;
    mon_q.delete();
    do_req(48'h2);
    c = 0;
    while (r_acc < 2 && c < 50) begin step; c++; end
    check("mid_two_beats", r_acc, 2);
    check("mid_err_count", err_count, exp_err + 1);
    rst = 1'b1;
    step;
    check("mid_rst_req_tready", req_tready, 0);
    check("mid_rst_resp_tvalid", resp_tvalid, 0);
    check("mid_rst_resp_tdata", resp_tdata, 0);
    check("mid_rst_resp_flags", {resp_tlast, resp_terr}, 0);
    check("mid_rst_arvalid", m_axi_arvalid, 0);
    check("mid_rst_araddr", m_axi_araddr, 0);
    check("mid_rst_rready", m_axi_rready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err_count", err_count, 0);
    rst = 1'b0; exp_err = 0; err_mask = 4'b0000; resp_tready = 1'b1;
    mon_q.delete();
    step;
    do_req(48'h1);
    wait_done(4);
    check("post_rst_araddr", ar_seen_addr, 48'h1100);
    check_beats("post_rst", 48'h1100, 4'b0000);
    check("post_rst_err_count", err_count, 0);

    check("handshake_stable", stab_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
